// File: rtl/branch_resolve_pht_if.sv
// branch_resolve_pht_if: lookup, resolve and perf signals of branch_resolve_pht; master drives requests, slave is the unit
interface branch_resolve_pht_if #(parameter int PERF_WIDTH = 32);
  logic                  lookup_en;
  logic [31:0]           lookup_pc;
  logic                  pred_take;
  logic                  br_valid;
  logic [3:0]            branch_type;
  logic [31:0]           br_pc;
  logic [31:0]           rs_value;
  logic [31:0]           rt_value;
  logic                  pred_take_in;
  logic                  stall;
  logic                  flush;
  logic                  res_valid;
  logic                  branch_take;
  logic                  pred_fail;
  logic [PERF_WIDTH-1:0] perf_branches;
  logic [PERF_WIDTH-1:0] perf_mispredicts;
  modport master (
    output lookup_en, lookup_pc, br_valid, branch_type, br_pc, rs_value, rt_value, pred_take_in, stall, flush,
    input  pred_take, res_valid, branch_take, pred_fail, perf_branches, perf_mispredicts
  );
  modport slave (
    input  lookup_en, lookup_pc, br_valid, branch_type, br_pc, rs_value, rt_value, pred_take_in, stall, flush,
    output pred_take, res_valid, branch_take, pred_fail, perf_branches, perf_mispredicts
  );
endinterface

// File: rtl/branch_resolve_pht.sv
// branch_resolve_pht: branch resolve + saturating-counter PHT; ports clk, resetn (async low), bus (lookup_en/pc -> pred_take, br_* resolve -> res_valid/branch_take/pred_fail, perf counters)
module branch_resolve_pht #(
  parameter int PHT_DEPTH  = 64,
  parameter int CTR_WIDTH  = 2,
  parameter int PERF_WIDTH = 32
) (
  input logic                 clk,
  input logic                 resetn,
  branch_resolve_pht_if.slave bus
);
  localparam int IDX_W = $clog2(PHT_DEPTH);
  localparam logic [CTR_WIDTH-1:0] CTR_INIT = CTR_WIDTH'((1 << (CTR_WIDTH - 1)) - 1);
  localparam logic [3:0] BT_BEQ   = 4'd1;
  localparam logic [3:0] BT_BNE   = 4'd2;
  localparam logic [3:0] BT_BGEZ_ = 4'd3;
  localparam logic [3:0] BT_BGTZ  = 4'd4;
  localparam logic [3:0] BT_BLEZ  = 4'd5;
  localparam logic [3:0] BT_BLTZ_ = 4'd6;
  logic [CTR_WIDTH-1:0]  pht_q [PHT_DEPTH];
  logic [CTR_WIDTH-1:0]  pht_d [PHT_DEPTH];
  logic                  pred_take_q, pred_take_d;
  logic                  res_valid_q, res_valid_d;
  logic                  branch_take_q, branch_take_d;
  logic                  pred_fail_q, pred_fail_d;
  logic [PERF_WIDTH-1:0] perf_br_q, perf_br_d;
  logic [PERF_WIDTH-1:0] perf_mis_q, perf_mis_d;
  logic [IDX_W-1:0]      lk_idx, br_idx;
  logic [CTR_WIDTH-1:0]  ctr_old, ctr_new, lk_ctr;
  logic                  is_cond, taken, accept, miss, hold;
  logic                  unused_bits;
  assign lk_idx = bus.lookup_pc[IDX_W+1:2];
  assign br_idx = bus.br_pc[IDX_W+1:2];
  assign unused_bits = ^{bus.lookup_pc[31:IDX_W+2], bus.lookup_pc[1:0], bus.br_pc[31:IDX_W+2], bus.br_pc[1:0]};
  always_comb begin
    is_cond = bus.branch_type inside {BT_BEQ, BT_BNE, BT_BGEZ_, BT_BGTZ, BT_BLEZ, BT_BLTZ_};
    taken   = bus.branch_type == BT_BEQ  ? bus.rs_value == bus.rt_value :
              bus.branch_type == BT_BNE  ? bus.rs_value != bus.rt_value :
              bus.branch_type == BT_BGTZ ? $signed(bus.rs_value) > 0 :
              bus.branch_type == BT_BLEZ ? $signed(bus.rs_value) <= 0 :
              bus.branch_type == BT_BGEZ_ ? !bus.rs_value[31] :
              bus.branch_type == BT_BLTZ_ && bus.rs_value[31];
    accept  = bus.br_valid && is_cond && !bus.stall && !bus.flush;
    miss    = bus.pred_take_in ^ taken;
    hold    = bus.stall && !bus.flush;
    ctr_old = pht_q[br_idx];
    ctr_new = taken ? (&ctr_old ? ctr_old : ctr_old + 1'b1) : (|ctr_old ? ctr_old - 1'b1 : ctr_old);
    pht_d = pht_q;
    if (accept) pht_d[br_idx] = ctr_new;
    // a same-cycle training write to the looked-up entry is forwarded
    lk_ctr        = (accept && br_idx == lk_idx) ? ctr_new : pht_q[lk_idx];
    pred_take_d   = bus.stall ? pred_take_q : bus.lookup_en && lk_ctr[CTR_WIDTH-1];
    res_valid_d   = accept ? 1'b1 : hold && res_valid_q;
    branch_take_d = accept ? taken : hold && branch_take_q;
    pred_fail_d   = accept ? miss : hold && pred_fail_q;
    perf_br_d     = (accept && !(&perf_br_q)) ? perf_br_q + 1'b1 : perf_br_q;
    perf_mis_d    = (accept && miss && !(&perf_mis_q)) ? perf_mis_q + 1'b1 : perf_mis_q;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pred_take_q   <= 1'b0;
      res_valid_q   <= 1'b0;
      branch_take_q <= 1'b0;
      pred_fail_q   <= 1'b0;
      perf_br_q     <= '0;
      perf_mis_q    <= '0;
      for (int i = 0; i < PHT_DEPTH; i++) pht_q[i] <= CTR_INIT;
    end else begin
      pred_take_q   <= pred_take_d;
      res_valid_q   <= res_valid_d;
      branch_take_q <= branch_take_d;
      pred_fail_q   <= pred_fail_d;
      perf_br_q     <= perf_br_d;
      perf_mis_q    <= perf_mis_d;
      pht_q         <= pht_d;
    end
  end
  assign bus.pred_take        = pred_take_q;
  assign bus.res_valid        = res_valid_q;
  assign bus.branch_take      = branch_take_q;
  assign bus.pred_fail        = pred_fail_q;
  assign bus.perf_branches    = perf_br_q;
  assign bus.perf_mispredicts = perf_mis_q;
endmodule

// File: doc/branch_resolve_pht.md
Name: branch_resolve_pht

Overview:
- Parametrised branch resolution unit with a local pattern history table (PHT) of saturating counters.
- Sits between IF and ID/EX:
  - The IF-side lookup port returns a taken prediction one cycle after the PC is presented.
  - The resolve port evaluates the conditional branch in the next stage and registers taken/mispredict one cycle later.
  - Resolution trains the PHT and updates saturating performance counters.

Parameters:
- PHT_DEPTH, 64, number of PHT entries; power of two, 4..256.
- CTR_WIDTH, 2, width of each saturating counter; 1..4.
- PERF_WIDTH, 32, width of each performance counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  asynchronous active-low reset.
- lookup_en  in  1  lookup request this cycle.
- lookup_pc  in  32  PC of the instruction being fetched.
- pred_take  out  1  registered prediction for the last accepted lookup.
- br_valid  in  1  resolve request for a decoded branch.
- branch_type  in  4  BT_* code from the global defines.
- br_pc  in  32  PC of the resolving branch.
- rs_value  in  32  forwarded rs operand.
- rt_value  in  32  forwarded rt operand.
- pred_take_in  in  1  prediction that travelled with this branch.
- stall  in  1  hold all registered outputs and block PHT/perf updates.
- flush  in  1  squash the resolve stage.
- res_valid  out  1  registered: a conditional branch was resolved.
- branch_take  out  1  registered resolved direction.
- pred_fail  out  1  registered pred_take_in XOR taken.
- perf_branches  out  PERF_WIDTH  resolved conditional branches.
- perf_mispredicts  out  PERF_WIDTH  mispredicted conditional branches.

Behaviour:
- Reset (asynchronous, resetn=0):
  - pred_take, res_valid, branch_take, pred_fail = 0; perf counters = 0.
  - Every PHT entry = weakly-not-taken, i.e. 2^(CTR_WIDTH-1)-1 (01 for width 2; 0 for width 1).
  - Reset mid-operation discards any in-flight lookup and resolve.
- Index: IDX_W = log2(PHT_DEPTH). Index = pc[IDX_W+1:2]; bits [1:0] are ignored.
- Conditional types and their taken conditions (signed compares on rs):
  - BT_BEQ: rs==rt. BT_BNE: rs!=rt.
  - BT_BGTZ: rs>0. BT_BLEZ: rs<=0.
  - BT_BGEZ_: rs[31]==0. BT_BLTZ_: rs[31]==1.
  - Any other code is non-conditional: no PHT or perf effect, and res_valid=0.
- Lookup (latency 1):
  - If lookup_en && !stall: pred_take <= MSB of PHT[idx(lookup_pc)].
  - If !lookup_en && !stall: pred_take <= 0.
  - If stall: pred_take holds.
- Resolve (latency 1). A resolve is accepted when br_valid && conditional && !stall && !flush. On the next edge after acceptance:
  - res_valid <= 1.
  - branch_take <= taken.
  - pred_fail <= pred_take_in ^ taken.
- Otherwise, when !stall: res_valid, branch_take, pred_fail <= 0.
- stall=1 holds all outputs and the PHT. flush=1 wins over stall and clears res_valid, branch_take and pred_fail.
- PHT training on an accepted resolve, at the same edge:
  - Taken: increment, saturating at 2^CTR_WIDTH-1.
  - Not taken: decrement, saturating at 0.
- Bypass: if a lookup and a training write hit the same index in the same cycle, pred_take reflects the post-update counter MSB.
- Perf counters, on an accepted resolve:
  - perf_branches += 1.
  - perf_mispredicts += 1 when pred_take_in ^ taken.
  - Both saturate at all-ones; no wrap.

Test Plan:
- Reset, then lookup pc=0x0000_0040 → pred_take=0 next cycle. Table is weakly-NT; perf counters stay 0.
- Resolve BEQ, pc=0x40, rs=rt=5, pred_take_in=0 → next cycle res_valid=1, branch_take=1, pred_fail=1, perf_mispredicts=1. Then lookup 0x40 → pred_take=1 (counter 10).
- Resolve BNE at 0x80 with taken four times, then not-taken once → counter saturates at 11, then reads 10. Lookup still gives pred_take=1. A further not-taken gives 01 → pred_take=0.
- Same-cycle lookup and taken-resolve at pc 0x100 from reset → pred_take=1 via the bypass.
- BLEZ rs=0x8000_0000 accepted with stall=1 → no change in outputs or counters. Deassert stall → resolve accepted; one cycle later branch_take=1, res_valid=1.
- flush and stall asserted together during a resolve → res_valid=0 and no PHT/perf update. Assert resetn=0 mid-stream → all outputs 0 immediately.
